// File: rtl/regfile_alu_shared_pkg.sv
// Types shared between the ALU and its consumers in the register-file slice.
package regfile_alu_shared_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    REGC = 2'b01,
    REGF = 2'b10,
    RFU  = 2'b11
  } write_sel_t;

endpackage

// File: rtl/regfile_pkg.sv
// Register-file types: register indices, register count and write-back source ids.
package regfile_pkg;

  localparam int REGISTERS = 8;

  typedef enum logic [2:0] {
    R_ZERO = 3'b000,
    R_GP1  = 3'b001,
    R_GP2  = 3'b010,
    R_GP3  = 3'b011,
    R_GP4  = 3'b100,
    R_GP5  = 3'b101,
    R_SP   = 3'b110,
    R_F    = 3'b111
  } reg_addr_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_arb2.sv
// wb_arb2: 2-way write-back grant logic. REGFILE_WB_RR_EN selects round-robin
// (1-bit pointer); otherwise fixed priority with the LSU winning conflicts.
module wb_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic lsu_valid,
  input  logic hold,
  output logic alu_grant,
  output logic lsu_grant
);

  logic open_gate;

  // No grants while frozen or while reset is asserted.
  assign open_gate = rst_n && !hold;

`ifdef REGFILE_WB_RR_EN
  wb_src_t ptr;

  always_comb begin
    alu_grant = open_gate && alu_valid && (!lsu_valid || ptr == SRC_ALU);
    lsu_grant = open_gate && lsu_valid && (!alu_valid || ptr == SRC_LSU);
  end

  // The pointer always points away from whoever was granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SRC_ALU;
    end else if (alu_grant) begin
      ptr <= SRC_LSU;
    end else if (lsu_grant) begin
      ptr <= SRC_ALU;
    end
  end
`else
  logic unused_clk;

  assign unused_clk = clk;

  always_comb begin
    lsu_grant = open_gate && lsu_valid;
    alu_grant = open_gate && alu_valid && !lsu_valid;
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port (ALU vs LSU).
// Conflict policy: round-robin when REGFILE_WB_RR_EN is defined, else LSU priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
  import regfile_alu_shared_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  write_sel_t            i_alu_sel,
  input  reg_addr_t             i_alu_dst,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic [DATA_WIDTH-1:0] i_alu_flags,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  reg_addr_t             i_lsu_dst,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  input  logic                  i_hold,
  output logic                  o_wr_en,
  output reg_addr_t             o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [REGISTERS-1:0]  o_pending,
  output logic                  o_err
);

  logic                  alu_grant;
  logic                  lsu_grant;
  logic                  nxt_we;
  reg_addr_t             nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  nxt_err;

  wb_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (i_alu_valid),
    .lsu_valid (i_lsu_valid),
    .hold      (i_hold),
    .alu_grant (alu_grant),
    .lsu_grant (lsu_grant)
  );

  assign o_alu_ready = alu_grant;
  assign o_lsu_ready = lsu_grant;

  // Writes to R_ZERO are accepted but never reach the port.
  always_comb begin
    nxt_we   = 1'b0;
    nxt_addr = R_ZERO;
    nxt_data = '0;
    nxt_err  = 1'b0;
    if (lsu_grant) begin
      nxt_addr = i_lsu_dst;
      nxt_data = i_lsu_data;
      nxt_we   = (i_lsu_dst != R_ZERO);
    end else if (alu_grant) begin
      unique case (i_alu_sel)
        REGC: begin
          nxt_addr = i_alu_dst;
          nxt_data = i_alu_data;
          nxt_we   = (i_alu_dst != R_ZERO);
        end
        REGF: begin
          nxt_addr = R_F;
          nxt_data = i_alu_flags;
          nxt_we   = 1'b1;
        end
        RFU:     nxt_err = 1'b1;
        default: nxt_err = 1'b0;
      endcase
    end
  end

  // The output register drains every cycle, so the only write granted but not
  // yet driven is the one being granted right now.
  always_comb begin
    o_pending = '0;
    if (nxt_we) begin
      o_pending[nxt_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= R_ZERO;
      o_wr_data <= '0;
      o_err     <= 1'b0;
    end else begin
      o_wr_en   <= nxt_we;
      o_wr_addr <= nxt_we ? nxt_addr : R_ZERO;
      o_wr_data <= nxt_we ? nxt_data : '0;
      o_err     <= nxt_err;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed checks plus random traffic
// against a behavioural model. Honours REGFILE_WB_RR_EN like the design.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;
  import regfile_alu_shared_pkg::*;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 alu_valid = 1'b0;
  write_sel_t           alu_sel = NONE;
  reg_addr_t            alu_dst = R_ZERO;
  logic [DW-1:0]        alu_data = '0;
  logic [DW-1:0]        alu_flags = '0;
  logic                 lsu_valid = 1'b0;
  reg_addr_t            lsu_dst = R_ZERO;
  logic [DW-1:0]        lsu_data = '0;
  logic                 hold = 1'b0;
  logic                 alu_ready;
  logic                 lsu_ready;
  logic                 wr_en;
  reg_addr_t            wr_addr;
  logic [DW-1:0]        wr_data;
  logic [REGISTERS-1:0] pending;
  logic                 err;

  int n_compared = 0;
  int n_mismatched = 0;

  // Model state: expected output-register contents and conflict preference.
  logic          exp_we = 1'b0;
  logic [2:0]    exp_addr = 3'd0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_err = 1'b0;
  logic          m_pref_lsu = 1'b0;
  logic          m_alu_acc = 1'b0;
  logic          m_lsu_acc = 1'b0;

`ifdef REGFILE_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  regfile_wb_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_sel   (alu_sel),
    .i_alu_dst   (alu_dst),
    .i_alu_data  (alu_data),
    .i_alu_flags (alu_flags),
    .i_lsu_valid (lsu_valid),
    .o_lsu_ready (lsu_ready),
    .i_lsu_dst   (lsu_dst),
    .i_lsu_data  (lsu_data),
    .i_hold      (hold),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_pending   (pending),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic av, input write_sel_t sel, input reg_addr_t adst,
                               input logic [DW-1:0] adata, input logic [DW-1:0] aflags,
                               input logic lv, input reg_addr_t ldst, input logic [DW-1:0] ldata,
                               input logic hd);
    alu_valid = av;
    alu_sel   = sel;
    alu_dst   = adst;
    alu_data  = adata;
    alu_flags = aflags;
    lsu_valid = lv;
    lsu_dst   = ldst;
    lsu_data  = ldata;
    hold      = hd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, NONE, R_ZERO, '0, '0, 1'b0, R_ZERO, '0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluated mid-cycle on settled inputs.
  always @(negedge clk) begin
    logic ga, gl, nw_we, nw_err;
    logic [2:0] nw_addr;
    logic [DW-1:0] nw_data;
    logic [31:0] exp_pend;
    if (!rst_n) begin
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_pending", 32'(pending), 32'd0);
      checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
      checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'd0);
      exp_we = 1'b0;
      exp_err = 1'b0;
      m_pref_lsu = 1'b0;
      m_alu_acc = 1'b0;
      m_lsu_acc = 1'b0;
    end else begin
      checkOutput("m_wr_en", 32'(wr_en), 32'(exp_we));
      if (exp_we) begin
        checkOutput("m_wr_addr", 32'(wr_addr), 32'(exp_addr));
        checkOutput("m_wr_data", 32'(wr_data), 32'(exp_data));
      end
      checkOutput("m_err", 32'(err), 32'(exp_err));

      ga = 1'b0;
      gl = 1'b0;
      if (!hold) begin
        if (alu_valid && lsu_valid) begin
          if (!RR || m_pref_lsu) gl = 1'b1;
          else ga = 1'b1;
        end else begin
          ga = alu_valid;
          gl = lsu_valid;
        end
      end
      nw_we = 1'b0;
      nw_err = 1'b0;
      nw_addr = 3'd0;
      nw_data = '0;
      if (gl) begin
        nw_addr = lsu_dst;
        nw_data = lsu_data;
        nw_we = (lsu_dst != R_ZERO);
      end else if (ga) begin
        if (alu_sel == REGC) begin
          nw_addr = alu_dst;
          nw_data = alu_data;
          nw_we = (alu_dst != R_ZERO);
        end else if (alu_sel == REGF) begin
          nw_addr = 3'd7;
          nw_data = alu_flags;
          nw_we = 1'b1;
        end else if (alu_sel == RFU) begin
          nw_err = 1'b1;
        end
      end
      exp_pend = nw_we ? (32'd1 << nw_addr) : 32'd0;
      checkOutput("m_alu_ready", 32'(alu_ready), 32'(ga));
      checkOutput("m_lsu_ready", 32'(lsu_ready), 32'(gl));
      checkOutput("m_pending", 32'(pending), exp_pend);

      exp_we = nw_we;
      exp_addr = nw_addr;
      exp_data = nw_data;
      exp_err = nw_err;
      if (ga) m_pref_lsu = 1'b1;
      else if (gl) m_pref_lsu = 1'b0;
      m_alu_acc = ga;
      m_lsu_acc = gl;
    end
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU REGC R_GP2 <= 1234
    nextCycle();
    applyStimulus(1'b1, REGC, R_GP2, 16'h1234, 16'h0000, 1'b0, R_ZERO, '0, 1'b0);
    @(negedge clk);
    checkOutput("regc_ready", 32'(alu_ready), 32'd1);
    checkOutput("regc_pend_n", 32'(pending), 32'h04);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("regc_wr_en", 32'(wr_en), 32'd1);
    checkOutput("regc_addr", 32'(wr_addr), 32'h2);
    checkOutput("regc_data", 32'(wr_data), 32'h1234);
    checkOutput("regc_pend_n1", 32'(pending), 32'h00);

    // ALU REGF flags 0005
    nextCycle();
    applyStimulus(1'b1, REGF, R_GP1, 16'hBEEF, 16'h0005, 1'b0, R_ZERO, '0, 1'b0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("regf_addr", 32'(wr_addr), 32'h7);
    checkOutput("regf_data", 32'(wr_data), 32'h0005);

    // LSU to R_ZERO: accepted, dropped
    nextCycle();
    applyStimulus(1'b0, NONE, R_ZERO, '0, '0, 1'b1, R_ZERO, 16'hFFFF, 1'b0);
    @(negedge clk);
    checkOutput("zero_ready", 32'(lsu_ready), 32'd1);
    checkOutput("zero_pend", 32'(pending), 32'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("zero_wr_en", 32'(wr_en), 32'd0);

    // Four-cycle conflict
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b1, REGC, R_GP3, 16'hA000 + 16'(i), '0, 1'b1, R_GP4, 16'h5000 + 16'(i), 1'b0);
      @(negedge clk);
      checkOutput($sformatf("conf%0d_alu", i), 32'(alu_ready), (RR && i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("conf%0d_lsu", i), 32'(lsu_ready), (RR && i % 2 == 0) ? 32'd0 : 32'd1);
    end
    nextCycle();
    idle();

    // Hold freezes both requesters
    nextCycle();
    applyStimulus(1'b1, REGC, R_SP, 16'h7777, '0, 1'b1, R_GP5, 16'h8888, 1'b1);
    @(negedge clk);
    checkOutput("hold_alu", 32'(alu_ready), 32'd0);
    checkOutput("hold_lsu", 32'(lsu_ready), 32'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("hold_wr_en", 32'(wr_en), 32'd0);

    // RFU: error pulse only
    nextCycle();
    applyStimulus(1'b1, RFU, R_GP1, 16'h1111, '0, 1'b0, R_ZERO, '0, 1'b0);
    @(negedge clk);
    checkOutput("rfu_ready", 32'(alu_ready), 32'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("rfu_err", 32'(err), 32'd1);
    checkOutput("rfu_wr_en", 32'(wr_en), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rfu_err_end", 32'(err), 32'd0);

    // Reset while a write is in flight
    nextCycle();
    applyStimulus(1'b1, REGC, R_GP5, 16'hCAFE, '0, 1'b0, R_ZERO, '0, 1'b0);
    nextCycle();
    idle();
    checkOutput("pre_rst_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst_pend", 32'(pending), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, REGC, R_GP1, 16'h0101, '0, 1'b1, R_GP2, 16'h0202, 1'b0);
    @(negedge clk);
    checkOutput("postrst_alu", 32'(alu_ready), RR ? 32'd1 : 32'd0);
    checkOutput("postrst_lsu", 32'(lsu_ready), RR ? 32'd0 : 32'd1);
    nextCycle();
    idle();

    // Random traffic; requesters keep valid and payload until accepted
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      if (!alu_valid || m_alu_acc) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_sel   = write_sel_t'($urandom_range(0, 3));
        alu_dst   = reg_addr_t'($urandom_range(0, 7));
        alu_data  = DW'($urandom);
        alu_flags = DW'($urandom);
      end
      if (!lsu_valid || m_lsu_acc) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_dst   = reg_addr_t'($urandom_range(0, 7));
        lsu_data  = DW'($urandom);
      end
      hold = ($urandom_range(0, 7) == 0);
    end
    nextCycle();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
